adc_sequencer: RTL and testbench
================================

Name: adc_sequencer

Overview:
- Single-clock conversion timing generator and result collector that sits directly upstream of adc_digital.
- Produces mutually exclusive seq_init / seq_samp / seq_comp / seq_update phase strobes for one SAR conversion, or back-to-back conversions.
- Captures the comparator decision on every update phase, MSB first, and presents the assembled code with a one-cycle valid pulse.

Parameters:
- NBITS, 16, maximum comparison cycles and result width.
- SAMPW, 4, width of the sampling-length config field.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_b  input  1  synchronous reset, active-low.
- start  input  1  request a conversion; sampled only in IDLE.
- abort  input  1  synchronous abort; highest priority after reset.
- continuous  input  1  1 = restart automatically after DONE.
- cfg_samp_len  input  SAMPW  sampling phase lasts cfg_samp_len+1 cycles.
- cfg_ncomp  input  $clog2(NBITS+1)  comparisons per conversion; 0 or >NBITS treated as NBITS.
- comp_out  input  1  comparator decision from adc_digital.
- seq_init, seq_samp, seq_comp, seq_update  output  1 each  phase strobes to adc_digital.
- busy  output  1  high from INIT through DONE inclusive.
- result  output  NBITS  last completed code, right-aligned.
- result_valid  output  1  one-cycle pulse when result updates.

Behaviour:
- Reset: all outputs are registered and reset to 0; FSM goes to IDLE; bit counter and shift register clear.
- Config latching: cfg_samp_len, cfg_ncomp (after clamp) and continuous are latched on entry to INIT and held for that conversion.
- State IDLE: all strobes 0, busy 0. start=1 moves to INIT next cycle.
- State INIT: seq_init=1 for 1 cycle; shift register clears.
- State SAMP: seq_samp=1 for S+1 cycles, where S = latched cfg_samp_len; S=0 gives 1 cycle.
- State COMP: seq_comp=1 for 1 cycle.
- State UPDATE: seq_update=1 for 1 cycle; on the edge ending this cycle, shift <= {shift[NBITS-2:0], comp_out} and the bit counter increments. After N captures go to DONE, otherwise back to COMP.
- State DONE: result <= shift; result_valid=1 and busy=1 for 1 cycle. Next state is INIT if latched continuous=1, else IDLE.
- Timing, with start high in cycle 0 while in IDLE:
  - seq_init in cycle 1.
  - seq_samp in cycles 2..2+S.
  - seq_comp in cycles 3+S+2k and seq_update in cycles 4+S+2k, for k=0..N-1.
  - DONE in cycle 3+S+2N.
  - Continuous-mode period (INIT to INIT) is 3+S+2N cycles.
- Strobes are never simultaneously high; all strobes are 0 in IDLE.
- start while busy is ignored, with no queuing.
- abort=1 in any state: next cycle is IDLE, strobes 0, busy 0. No result_valid; result keeps its previous value; partial shift contents are discarded.
- abort and start high together in IDLE: abort wins and the FSM stays in IDLE.
- rst_b low mid-conversion: everything returns to reset values on that edge, including result.
- Unused upper result bits (N<NBITS) read 0.

Optional Feature:
- Macro: ADC_SEQ_CONVCNT_EN.
- When defined:
  - Adds output conv_count [15:0].
  - conv_count resets to 0 and increments in the same cycle result_valid is asserted.
  - Wraps 0xFFFF -> 0x0000.
  - Aborted conversions are not counted.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single conversion. NBITS=16, S=2, N=4, comp_out 1,0,1,1 at updates. Start pulse in cycle 0 ->
  - seq_init cycle 1; seq_samp cycles 2-4.
  - seq_comp cycles 5,7,9,11; seq_update cycles 6,8,10,12.
  - result_valid cycle 13 with result=0x000B; busy low in cycle 14.
- Continuous mode, S=0, N=16, comp_out held 1 -> result_valid every 35 cycles with result=0xFFFF. Clearing continuous mid-conversion takes effect only after the next DONE.
- Abort during COMP of bit 3 with prior result 0x000B -> IDLE next cycle, no result_valid, result stays 0x000B. A new start then yields a full conversion.
- cfg_ncomp=0 and cfg_ncomp=31 -> both perform 16 comparisons. start asserted while busy -> no extra conversion.
- rst_b low during SAMP -> all outputs 0 on the next edge, including result.
- With ADC_SEQ_CONVCNT_EN defined: preload near wrap, i.e. run 65536 continuous conversions with S=0, N=1 -> conv_count wraps to 0x0000. Aborted conversions do not increment it.

Source files
------------

// File: rtl/adc_sequencer.sv
// rtl/adc_sequencer.sv - SAR conversion phase sequencer and result collector
// Optional conversion counter output enabled by defining ADC_SEQ_CONVCNT_EN.
module adc_sequencer #(
  parameter int NBITS = 16,
  parameter int SAMPW = 4,
  localparam int CW = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic [SAMPW-1:0] cfg_samp_len,
  input  logic [CW-1:0]    cfg_ncomp,
  input  logic             comp_out,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_comp,
  output logic             seq_update,
  output logic             busy,
  output logic [NBITS-1:0] result,
`ifdef ADC_SEQ_CONVCNT_EN
  output logic [15:0]      conv_count,
`endif
  output logic             result_valid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SAMP   = 3'd2,
    COMP   = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [SAMPW-1:0] samp_len_q;
  logic [SAMPW-1:0] samp_cnt;
  logic [CW-1:0]    ncomp_q;
  logic [CW-1:0]    ncomp_eff;
  logic [CW-1:0]    bit_cnt;
  logic             cont_q;
  logic [NBITS-1:0] shift;
  logic [NBITS-1:0] shift_next;

  // Out-of-range comparison counts fall back to a full-width conversion.
  assign ncomp_eff = (cfg_ncomp == '0 || cfg_ncomp > CW'(NBITS)) ? CW'(NBITS) : cfg_ncomp;

  always_comb begin
    state_next = state;
    shift_next = {shift[NBITS-2:0], comp_out};
    case (state)
      IDLE:   if (start) state_next = INIT;
      INIT:   state_next = SAMP;
      SAMP:   if (samp_cnt == samp_len_q) state_next = COMP;
      COMP:   state_next = UPDATE;
      UPDATE: state_next = (bit_cnt == ncomp_q - CW'(1)) ? DONE : COMP;
      DONE:   state_next = cont_q ? INIT : IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Strobes are registered from the next state so they line up with the state they name.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state        <= IDLE;
      samp_len_q   <= '0;
      samp_cnt     <= '0;
      ncomp_q      <= '0;
      bit_cnt      <= '0;
      cont_q       <= 1'b0;
      shift        <= '0;
      result       <= '0;
      seq_init     <= 1'b0;
      seq_samp     <= 1'b0;
      seq_comp     <= 1'b0;
      seq_update   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
`ifdef ADC_SEQ_CONVCNT_EN
      conv_count   <= '0;
`endif
    end else begin
      state        <= state_next;
      seq_init     <= (state_next == INIT);
      seq_samp     <= (state_next == SAMP);
      seq_comp     <= (state_next == COMP);
      seq_update   <= (state_next == UPDATE);
      busy         <= (state_next != IDLE);
      result_valid <= (state_next == DONE);

      if (state == SAMP) samp_cnt <= samp_cnt + 1'b1;

      if (state == UPDATE) begin
        shift   <= shift_next;
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == UPDATE && state_next == DONE) begin
        result <= shift_next;
`ifdef ADC_SEQ_CONVCNT_EN
        conv_count <= conv_count + 16'd1;
`endif
      end

      if (state_next == INIT) begin
        samp_len_q <= cfg_samp_len;
        ncomp_q    <= ncomp_eff;
        cont_q     <= continuous;
      end

      // Fresh conversion or abort: drop any partial capture.
      if (state_next == INIT || state_next == IDLE) begin
        shift    <= '0;
        bit_cnt  <= '0;
        samp_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// tb/tb_adc_sequencer.sv - self-checking bench for adc_sequencer
// Checks strobe timing and results against closed-form cycle formulas.
module tb_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic        abort;
  logic        continuous;
  logic [3:0]  cfg_samp_len;
  logic [4:0]  cfg_ncomp;
  logic        comp_out;
  logic        seq_init;
  logic        seq_samp;
  logic        seq_comp;
  logic        seq_update;
  logic        busy;
  logic [15:0] result;
  logic        result_valid;
`ifdef ADC_SEQ_CONVCNT_EN
  logic [15:0] conv_count;
`endif

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] model_result = '0;
  int          model_count = 0;
  bit          done_flag;

  adc_sequencer #(.NBITS(16), .SAMPW(4)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .start        (start),
    .abort        (abort),
    .continuous   (continuous),
    .cfg_samp_len (cfg_samp_len),
    .cfg_ncomp    (cfg_ncomp),
    .comp_out     (comp_out),
    .seq_init     (seq_init),
    .seq_samp     (seq_samp),
    .seq_comp     (seq_comp),
    .seq_update   (seq_update),
    .busy         (busy),
    .result       (result),
`ifdef ADC_SEQ_CONVCNT_EN
    .conv_count   (conv_count),
`endif
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_init"}, seq_init, 0);
    chk({tag, "_samp"}, seq_samp, 0);
    chk({tag, "_comp"}, seq_comp, 0);
    chk({tag, "_upd"}, seq_update, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_result"}, result, model_result);
`ifdef ADC_SEQ_CONVCNT_EN
    chk({tag, "_count"}, conv_count, model_count);
`endif
  endtask

  // Called at the falling edge of "cycle 0" (the cycle whose closing edge enters INIT).
  task automatic run_conv(input int s, input int ncfg, input bit launch, input logic [15:0] bitsv,
                          input int kill_at, input bit kill_rst, input int clr_at, output bit completed);
    int          n;
    int          len;
    int          k;
    logic [15:0] exp_res;
    n = (ncfg == 0 || ncfg > 16) ? 16 : ncfg;
    len = 3 + s + 2 * n;
    exp_res = '0;
    for (int i = 0; i < n; i++) exp_res = (exp_res << 1) | 16'(bitsv[i]);
    cfg_samp_len = 4'(s);
    cfg_ncomp = 5'(ncfg);
    if (launch) start = 1'b1;
    completed = 1'b0;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      chk("init", seq_init, c == 1);
      chk("samp", seq_samp, c >= 2 && c <= 2 + s);
      chk("comp", seq_comp, c >= 3 + s && c <= 2 + s + 2 * n && ((c - 3 - s) % 2 == 0));
      chk("update", seq_update, c >= 4 + s && c <= 3 + s + 2 * n && ((c - 4 - s) % 2 == 0));
      chk("busy", busy, 1);
      chk("valid", result_valid, c == len);
      chk("result", result, (c == len) ? exp_res : model_result);
`ifdef ADC_SEQ_CONVCNT_EN
      chk("count", conv_count, (c == len) ? 16'(model_count + 1) : 16'(model_count));
`endif
      start = (c < len) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == kill_at) begin
        if (kill_rst) rst_b = 1'b0;
        else abort = 1'b1;
        @(negedge clk);
        rst_b = 1'b1;
        abort = 1'b0;
        start = 1'b0;
        if (kill_rst) begin
          model_result = '0;
          model_count = 0;
        end
        check_idle("kill");
        return;
      end
      if (c < len) begin
        cfg_samp_len = 4'($urandom);
        cfg_ncomp = 5'($urandom);
      end
      k = (c - 4 - s) / 2;
      if (c >= 4 + s && ((c - 4 - s) % 2 == 0) && k < n) comp_out = bitsv[k];
      else comp_out = 1'($urandom);
      if (c == clr_at) continuous = 1'b0;
    end
    model_result = exp_res;
    model_count = (model_count + 1) & 16'hFFFF;
    completed = 1'b1;
  endtask

  initial begin
    rst_b = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    continuous = 1'b0;
    cfg_samp_len = '0;
    cfg_ncomp = '0;
    comp_out = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_b = 1'b1;
    @(negedge clk);
    check_idle("idle");

    // Directed single conversion: S=2, N=4, bits 1,0,1,1 -> 0x000B.
    run_conv(2, 4, 1'b1, 16'h000D, 0, 1'b0, 0, done_flag);
    chk("single_done", done_flag, 1);
    chk("single_code", model_result, 16'h000B);
    @(negedge clk);
    check_idle("single_after");

    // start and abort together while idle: stays idle.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_idle("start_abort");
    @(negedge clk);
    check_idle("start_abort2");

    // Abort during COMP of bit 3 (cycle 3+S+6), result must hold 0x000B.
    run_conv(2, 4, 1'b1, 16'(5), 3 + 2 + 6, 1'b0, 0, done_flag);
    chk("abort_code", result, 16'h000B);
    run_conv(1, 6, 1'b1, 16'($urandom), 0, 1'b0, 0, done_flag);
    chk("post_abort_done", done_flag, 1);
    @(negedge clk);
    check_idle("post_abort");

    // Clamp: 0 and 31 both give 16 comparisons.
    run_conv(0, 0, 1'b1, 16'($urandom), 0, 1'b0, 0, done_flag);
    @(negedge clk);
    check_idle("ncomp0");
    run_conv(3, 31, 1'b1, 16'($urandom), 0, 1'b0, 0, done_flag);
    @(negedge clk);
    check_idle("ncomp31");

    // Continuous mode, 35-cycle period; clearing continuous takes effect after the next DONE.
    continuous = 1'b1;
    run_conv(0, 16, 1'b1, 16'hFFFF, 0, 1'b0, 0, done_flag);
    chk("cont_code", result, 16'hFFFF);
    run_conv(0, 16, 1'b0, 16'hFFFF, 0, 1'b0, 10, done_flag);
    run_conv(0, 16, 1'b0, 16'hFFFF, 0, 1'b0, 0, done_flag);
    chk("cont_last", done_flag, 1);
    @(negedge clk);
    check_idle("cont_stop");

    // Randomized conversions with occasional aborts.
    for (int it = 0; it < 10; it++) begin
      int s_r;
      int n_r;
      int kill;
      s_r = $urandom_range(0, 15);
      n_r = $urandom_range(0, 31);
      kill = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      run_conv(s_r, n_r, 1'b1, 16'($urandom), kill, 1'b0, 0, done_flag);
      if (done_flag) begin
        @(negedge clk);
        check_idle("rand_idle");
      end
    end

    // Reset during SAMP clears everything, including result.
    run_conv(3, 5, 1'b1, 16'($urandom), 3, 1'b1, 0, done_flag);
    chk("rst_result", result, 0);
    run_conv(0, 3, 1'b1, 16'($urandom), 0, 1'b0, 0, done_flag);
    @(negedge clk);
    check_idle("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
